// File: rtl/tank_motion_ctrl.sv
// Player tank and bullet state, updated once per video frame.
// Latency: frame_start -> MOVE +1, BULLET +2, update_done pulse +3 cycles.
// Backpressure: none; frame_start outside IDLE is dropped, keys are sampled every cycle.
//
// Ports:
//   clk_25m, rst_n          pixel clock, async active-low reset
//   frame_start             one-cycle pulse at the top-left pixel of each frame
//   direction[3:0], fire    one-hot keys {up,down,left,right}; fire key (level)
//   tank_x/y/dir            tank tile position and facing (0 up,1 down,2 left,3 right)
//   bullet_valid/x/y/dir    single bullet state, same direction encoding
//   update_done             one-cycle pulse when the frame update has finished
`timescale 1ns/1ps
module tank_motion_ctrl #(
  parameter int GRID_W   = 64,
  parameter int GRID_H   = 48,
  parameter int MOVE_DIV = 4,
  parameter int START_X  = 32,
  parameter int START_Y  = 40
) (
  input  logic       clk_25m,
  input  logic       rst_n,
  input  logic       frame_start,
  input  logic [3:0] direction,
  input  logic       fire,
  output logic [5:0] tank_x,
  output logic [5:0] tank_y,
  output logic [1:0] tank_dir,
  output logic       bullet_valid,
  output logic [5:0] bullet_x,
  output logic [5:0] bullet_y,
  output logic [1:0] bullet_dir,
  output logic       update_done
);

  typedef enum logic [1:0] {IDLE, MOVE, BULLET, DONE} state_t;

  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_DOWN  = 2'd1;
  localparam logic [1:0] DIR_LEFT  = 2'd2;
  localparam logic [1:0] DIR_RIGHT = 2'd3;

  localparam logic [5:0] X_MAX   = 6'(GRID_W - 1);
  localparam logic [5:0] Y_MAX   = 6'(GRID_H - 1);
  localparam logic [5:0] X_RESET = 6'(START_X);
  localparam logic [5:0] Y_RESET = 6'(START_Y);
  localparam logic [3:0] CNT_MAX = 4'(MOVE_DIV - 1);

  state_t     state_q, state_d;
  logic [1:0] dir_hold;
  logic       move_req;
  logic       fire_pend;
  logic [3:0] move_cnt;

  logic       key_vld;
  logic [1:0] key_enc;

  // One tile step in direction d. The edge test comes first so the 6-bit
  // arithmetic never wraps; on an edge the position is returned unchanged
  // and the blocked flag is set.
  function automatic logic [12:0] step_tile(input logic [5:0] x, input logic [5:0] y,
                                            input logic [1:0] d);
    logic       blocked;
    logic [5:0] nx;
    logic [5:0] ny;
    blocked = 1'b0;
    nx      = x;
    ny      = y;
    case (d)
      DIR_UP:    if (y == 6'd0)  blocked = 1'b1; else ny = y - 6'd1;
      DIR_DOWN:  if (y == Y_MAX) blocked = 1'b1; else ny = y + 6'd1;
      DIR_LEFT:  if (x == 6'd0)  blocked = 1'b1; else nx = x - 6'd1;
      default:   if (x == X_MAX) blocked = 1'b1; else nx = x + 6'd1;
    endcase
    return {blocked, nx, ny};
  endfunction

  logic [12:0] tank_step;
  logic [12:0] bullet_step;

  assign tank_step   = step_tile(tank_x, tank_y, dir_hold);
  assign bullet_step = step_tile(bullet_x, bullet_y, bullet_dir);

  // Only a clean one-hot key press counts; chords and releases are ignored.
  always_comb begin
    key_vld = 1'b1;
    key_enc = DIR_UP;
    case (direction)
      4'b1000: key_enc = DIR_UP;
      4'b0100: key_enc = DIR_DOWN;
      4'b0010: key_enc = DIR_LEFT;
      4'b0001: key_enc = DIR_RIGHT;
      default: key_vld = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (frame_start) state_d = MOVE;
      MOVE:    state_d = BULLET;
      BULLET:  state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_25m or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk_25m or negedge rst_n) begin
    if (!rst_n) begin
      tank_x       <= X_RESET;
      tank_y       <= Y_RESET;
      tank_dir     <= DIR_UP;
      bullet_valid <= 1'b0;
      bullet_x     <= 6'd0;
      bullet_y     <= 6'd0;
      bullet_dir   <= DIR_UP;
      update_done  <= 1'b0;
      move_cnt     <= 4'd0;
      dir_hold     <= DIR_UP;
      move_req     <= 1'b0;
      fire_pend    <= 1'b0;
    end else begin
      // DONE is the cycle after BULLET, so registering this gives the pulse in DONE.
      update_done <= (state_q == BULLET);

      // A key seen in the MOVE cycle itself re-arms the request.
      if (key_vld) begin
        dir_hold <= key_enc;
        move_req <= 1'b1;
      end else if (state_q == MOVE) begin
        move_req <= 1'b0;
      end

      // A fire press in the spawn cycle stays pending for the next bullet.
      if (fire) begin
        fire_pend <= 1'b1;
      end else if (state_q == BULLET && !bullet_valid && fire_pend) begin
        fire_pend <= 1'b0;
      end

      if (state_q == MOVE) begin
        move_cnt <= (move_cnt == CNT_MAX) ? 4'd0 : move_cnt + 4'd1;
        if (move_req) begin
          tank_dir <= dir_hold;
          if (move_cnt == CNT_MAX) begin
            tank_x <= tank_step[11:6];
            tank_y <= tank_step[5:0];
          end
        end
      end

      // Spawn reads tank_x/y, which MOVE updated one cycle earlier.
      if (state_q == BULLET) begin
        if (bullet_valid) begin
          if (bullet_step[12]) begin
            bullet_valid <= 1'b0;
          end else begin
            bullet_x <= bullet_step[11:6];
            bullet_y <= bullet_step[5:0];
          end
        end else if (fire_pend) begin
          bullet_valid <= 1'b1;
          bullet_x     <= tank_x;
          bullet_y     <= tank_y;
          bullet_dir   <= tank_dir;
        end
      end
    end
  end

endmodule
